// File: rtl/trace_term_monitor_if.sv
// Character stream interface for trace_term_monitor.
// The master side (the monitor) presents a character tagged with its source core index.
// The slave side (the consumer) accepts it with char_ready.
interface trace_term_monitor_if #(
    parameter int CW = 2
);
    logic          char_valid;
    logic [7:0]    char_data;
    logic [CW-1:0] char_core;
    logic          char_ready;

    modport master (
        output char_valid,
        output char_data,
        output char_core,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        input  char_core,
        output char_ready
    );
endinterface

// File: rtl/trace_term_monitor.sv
// trace_term_monitor: watches the retired-instruction trace of NUM_CORES cores.
//  - l.nop 0x1 marks a core exited and captures r3 as its exit code; term_all = &term.
//  - l.nop 0x4 emits r3[7:0] as a character. Each core owns one pending slot. A
//    round-robin arbiter moves pending characters into a shared FIFO that drives the
//    char_if stream.
// Optional build macro TRACE_WDT_EN adds a watchdog. The watchdog raises a sticky
// wdt_timeout after WDT_CYCLES cycles pass with no active trace, unless all cores
// have exited. Without the macro, wdt_timeout is tied low.
module trace_term_monitor #(
    parameter int          NUM_CORES  = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter int unsigned WDT_CYCLES = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CORES-1:0]     i_trace_valid,
    input  logic [32*NUM_CORES-1:0]  i_trace_insn,
    input  logic [32*NUM_CORES-1:0]  i_trace_r3,
    trace_term_monitor_if.master     char_if,
    output logic                     o_char_drop,
    output logic [NUM_CORES-1:0]     o_term,
    output logic [32*NUM_CORES-1:0]  o_exit_code,
    output logic                     o_term_all,
    output logic                     o_wdt_timeout
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  CNT_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]  INSN_EXIT  = 32'h1500_0001;
    localparam logic [31:0]  INSN_PUTC  = 32'h1500_0004;

    logic [NUM_CORES-1:0]    r_term;
    logic [32*NUM_CORES-1:0] r_exit_code;
    logic [NUM_CORES-1:0]    r_pend;
    logic [7:0]              r_pch [NUM_CORES];
    logic                    r_drop;
    logic [CW-1:0]           r_rr;
    logic [CW+7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wp;
    logic [AW-1:0]           r_rp;
    logic [AW:0]             r_count;

    logic [NUM_CORES-1:0]    w_active;
    logic [NUM_CORES-1:0]    w_exit;
    logic [NUM_CORES-1:0]    w_putc;
    logic                    w_gnt_vld;
    logic [CW-1:0]           w_gnt_idx;
    logic [7:0]              w_gnt_data;
    logic [NUM_CORES-1:0]    w_gnt_oh;
    logic                    w_push;
    logic                    w_pop;

    // Decode exit/putc events; a core that has already exited is ignored.
    always_comb begin
        w_active = '0;
        w_exit   = '0;
        w_putc   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_active[i] = i_trace_valid[i] & ~r_term[i];
            w_exit[i]   = w_active[i] && (i_trace_insn[32*i +: 32] == INSN_EXIT);
            w_putc[i]   = w_active[i] && (i_trace_insn[32*i +: 32] == INSN_PUTC);
        end
    end

    // Round-robin arbiter: the first pending slot at or after r_rr, wrapping.
    // It gives no grant while the FIFO is full.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        if (r_count != CNT_FULL) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!w_gnt_vld && r_pend[j] && (j >= int'(r_rr))) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_idx  = CW'(j);
                    w_gnt_data = r_pch[j];
                end
            end
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!w_gnt_vld && r_pend[j]) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_idx  = CW'(j);
                    w_gnt_data = r_pch[j];
                end
            end
        end
    end

    // One-hot form of the grant, used to free the granted pending slot.
    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == CW'(i));
        end
    end

    assign w_push = w_gnt_vld;
    assign w_pop  = (r_count != '0) && char_if.char_ready;

    // Capture exits and maintain per-core pending character slots and the drop pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_term      <= '0;
            r_exit_code <= '0;
            r_pend      <= '0;
            r_drop      <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_pch[i] <= '0;
            end
        end else begin
            r_drop <= |(w_putc & r_pend & ~w_gnt_oh);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_exit[i]) begin
                    r_term[i]             <= 1'b1;
                    r_exit_code[32*i +: 32] <= i_trace_r3[32*i +: 32];
                end
                // A slot being granted this cycle is free to take the new character.
                if (w_putc[i] && (!r_pend[i] || w_gnt_oh[i])) begin
                    r_pend[i] <= 1'b1;
                    r_pch[i]  <= i_trace_r3[32*i +: 8];
                end else if (w_gnt_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Character FIFO and round-robin pointer advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= {w_gnt_idx, w_gnt_data};
                r_wp        <= r_wp + AW'(1);
                r_rr        <= (w_gnt_idx == CW'(NUM_CORES-1)) ? '0 : w_gnt_idx + CW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign char_if.char_valid = (r_count != '0);
    assign char_if.char_data  = r_mem[r_rp][7:0];
    assign char_if.char_core  = r_mem[r_rp][CW+7:8];
    assign o_char_drop        = r_drop;
    assign o_term             = r_term;
    assign o_exit_code        = r_exit_code;
    assign o_term_all         = &r_term;

`ifdef TRACE_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] r_wdt_cnt;
    logic          r_wdt;

    // Watchdog: any active trace restarts it. It counts while some core is still
    // running and saturates at WDT_CYCLES. The timeout flag is sticky.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b0;
        end else if (|w_active) begin
            r_wdt_cnt <= '0;
        end else if (!o_term_all && (r_wdt_cnt != WW'(WDT_CYCLES))) begin
            r_wdt_cnt <= r_wdt_cnt + WW'(1);
            if (r_wdt_cnt == WW'(WDT_CYCLES - 1)) begin
                r_wdt <= 1'b1;
            end
        end
    end

    assign o_wdt_timeout = r_wdt;
`else
    assign o_wdt_timeout = 1'b0;
`endif
endmodule
